// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - iterative radix-2 shift-add multiplier (mul/mulh/mulhu) with stall handshake
module mul_sequencer #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [3:0] OP_MUL   = 4'b0101;
    localparam logic [3:0] OP_MULH  = 4'b0110;
    localparam logic [3:0] OP_MULHU = 4'b0111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic               sign_neg;
    logic               want_low;

    logic               valid_op;
    logic               is_mulh;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_fixed;

    // Operand decode, magnitude conversion and the per-iteration partial sum
    always_comb begin
        valid_op  = (aluop == OP_MUL) || (aluop == OP_MULH) || (aluop == OP_MULHU);
        is_mulh   = (aluop == OP_MULH);
        // Most-negative input yields 2^(W-1), which still fits as an unsigned magnitude
        mag_a     = (is_mulh && a[WIDTH-1]) ? (~a + 1'b1) : a;
        mag_b     = (is_mulh && b[WIDTH-1]) ? (~b + 1'b1) : b;
        sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
        acc_fixed = sign_neg ? (~acc + 1'b1) : acc;
    end

    // Core stalls from the accepting cycle until the done cycle
    always_comb begin
        stall = ((state == S_IDLE) && start && valid_op) || (state == S_RUN) || (state == S_FIX);
    end

    // Sequencing FSM with datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            sign_neg <= 1'b0;
            want_low <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && valid_op) begin
                        state    <= S_RUN;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        mcand    <= mag_a;
                        mplier   <= mag_b;
                        acc      <= '0;
                        sign_neg <= is_mulh && (a[WIDTH-1] ^ b[WIDTH-1]);
                        want_low <= (aluop == OP_MUL);
                    end
                end
                S_RUN: begin
                    acc    <= {sum, acc[WIDTH-1:1]};
                    mplier <= mplier >> 1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        cnt   <= '0;
                        state <= S_FIX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    acc    <= acc_fixed;
                    result <= want_low ? acc_fixed[WIDTH-1:0] : acc_fixed[2*WIDTH-1:WIDTH];
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - scoreboard bench for mul_sequencer with random and directed operands
module tb_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  aluop = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        flush = 1'b0;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad = 0;
    logic [31:0] sb[$];
    logic [31:0] last_res = 32'd0;

    mul_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .aluop(aluop), .a(a), .b(b),
        .flush(flush), .stall(stall), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        longint sp;
        logic [63:0] up;
        sp = longint'($signed(x)) * longint'($signed(y));
        up = {32'd0, x} * {32'd0, y};
        case (op)
            4'b0101: ref_mul = up[31:0];
            4'b0110: ref_mul = sp[63:32];
            default: ref_mul = up[63:32];
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(done), 64'd0);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                check("result", 64'(result), 64'(e));
                last_res = e;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op; optionally inject a rejected start (mul 3*4) at cycle 5
    task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input bit intr);
        int n;
        bit got;
        start = 1'b1; aluop = op; a = x; b = y;
        sb.push_back(ref_mul(op, x, y));
        n = 0;
        got = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                check("latency", 64'(n), 64'd34);
                check("stall_at_done", 64'(stall), 64'd0);
                check("busy_at_done", 64'(busy), 64'd0);
            end else begin
                check("stall_in_flight", 64'(stall), 64'd1);
            end
            tick();
            start = 1'b0;
            n++;
            if (intr && n == 5) begin
                start = 1'b1; aluop = 4'b0101; a = 32'd3; b = 32'd4;
            end
        end
        if (!got) check("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #2;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        run_op(4'b0101, 32'd7, 32'd6, 0);
        run_op(4'b0111, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(4'b0101, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(4'b0110, 32'hFFFFFFFD, 32'd5, 0);
        run_op(4'b0110, 32'h80000000, 32'h80000000, 0);
        run_op(4'b0110, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(4'b0110, 32'h12345678, 32'hF0F0F0F0, 1);

        for (int i = 0; i < 24; i++) begin
            logic [3:0] op;
            op = 4'(5 + $urandom_range(0, 2));
            run_op(op, $urandom, $urandom, (i % 4) == 0);
        end

        // Non-multiply aluop: ignored entirely
        start = 1'b1; aluop = 4'b0011; a = 32'd9; b = 32'd9;
        @(negedge clk);
        check("invalid_op_stall", 64'(stall), 64'd0);
        tick();
        start = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        check("invalid_op_busy", 64'(busy), 64'd0);

        // Flush mid-run: back to IDLE, no done, result unchanged
        start = 1'b1; aluop = 4'b0110; a = 32'd100; b = 32'd200;
        tick();
        start = 1'b0;
        for (int i = 1; i < 20; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_stall", 64'(stall), 64'd0);
        for (int i = 0; i < 40; i++) tick();
        check("flush_result_kept", 64'(result), 64'(last_res));

        // Flush and start together: stays IDLE
        flush = 1'b1; start = 1'b1; aluop = 4'b0101; a = 32'd5; b = 32'd5;
        tick();
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        check("flush_start_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 40; i++) tick();
        check("flush_start_result", 64'(result), 64'(last_res));

        // Asynchronous reset in the middle of a run
        start = 1'b1; aluop = 4'b0111; a = 32'hDEADBEEF; b = 32'h12345678;
        tick();
        start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        check("midreset_result", 64'(result), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 40; i++) tick();
        check("midreset_no_done_result", 64'(result), 64'd0);
        run_op(4'b0101, 32'd2, 32'd2, 0);

        tick();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
